// File: rtl/mixer_pkg.sv
// Shared helpers for the layer mixer: pair enumeration and the default background colour.
package mixer_pkg;

  localparam logic [31:0] BG_RGB_DEFAULT = '0;

  function automatic int unsigned pair_count(input int unsigned n);
    return n * (n - 1) / 2;
  endfunction

  // Lexicographic index of pair (i,j), i<j, among n layers.
  function automatic int unsigned pair_index(input int unsigned i, input int unsigned j,
                                             input int unsigned n);
    return i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/mixer_pair_det.sv
// One layer pair's per-frame overlap accumulator and report latch.
// Optional saturating overlap counter enabled by MIXER_HIT_COUNT_EN.
module mixer_pair_det #(
  parameter int unsigned HIT_CNT_W = 10
) (
  input  logic clk_vga,
  input  logic rst,
  input  logic hit_px,
  input  logic frame_start,
  output logic hit
`ifdef MIXER_HIT_COUNT_EN
  , output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

  logic acc;

  // A hit coinciding with frame_start belongs to the frame that is starting.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      acc <= 1'b0;
      hit <= 1'b0;
    end else if (frame_start) begin
      hit <= acc;
      acc <= hit_px;
    end else begin
      acc <= acc | hit_px;
    end
  end

`ifdef MIXER_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      cnt     <= '0;
      hit_cnt <= '0;
    end else if (frame_start) begin
      hit_cnt <= cnt;
      cnt     <= HIT_CNT_W'(hit_px);
    end else if (hit_px && (cnt != '1)) begin
      cnt <= cnt + HIT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/layer_mixer.sv
// N-layer priority compositor with per-frame pairwise collision flags (2-cycle pipeline).
// Define MIXER_HIT_COUNT_EN to add saturating per-pair overlap counters on hit_cnt_o.
module layer_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned      LAYERS    = 4,
  parameter int unsigned      RGB_W     = 12,
  parameter logic [RGB_W-1:0] BG_RGB    = RGB_W'(BG_RGB_DEFAULT),
  parameter int unsigned      HIT_CNT_W = 10,
  localparam int unsigned     PAIRS     = pair_count(LAYERS)
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    disp_i,
  input  logic                    frame_start_i,
  input  logic [LAYERS*RGB_W-1:0] layer_rgb_i,
  input  logic [LAYERS-1:0]       layer_alpha_i,
  input  logic [LAYERS-1:0]       layer_en_i,
  output logic [RGB_W-1:0]        rgb_o,
  output logic                    disp_o,
  output logic [PAIRS-1:0]        hit_o,
  output logic                    hit_valid_o
`ifdef MIXER_HIT_COUNT_EN
  , output logic [PAIRS*HIT_CNT_W-1:0] hit_cnt_o
`endif
);

  logic [LAYERS*RGB_W-1:0] rgb1;
  logic [LAYERS-1:0]       a1;
  logic                    disp1;
  logic                    fs1;
  logic [RGB_W-1:0]        sel;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      rgb1        <= '0;
      a1          <= '0;
      disp1       <= 1'b0;
      fs1         <= 1'b0;
      rgb_o       <= '0;
      disp_o      <= 1'b0;
      hit_valid_o <= 1'b0;
    end else begin
      rgb1        <= layer_rgb_i;
      a1          <= layer_alpha_i & layer_en_i;
      disp1       <= disp_i;
      fs1         <= frame_start_i;
      rgb_o       <= disp1 ? sel : '0;
      disp_o      <= disp1;
      hit_valid_o <= fs1;
    end
  end

  // Scan from the lowest priority upward so the lowest opaque index wins.
  always_comb begin
    sel = BG_RGB;
    for (int unsigned k = 0; k < LAYERS; k++) begin
      if (a1[LAYERS-1-k]) sel = rgb1[(LAYERS-1-k)*RGB_W +: RGB_W];
    end
  end

  for (genvar i = 0; i < LAYERS - 1; i++) begin : g_i
    for (genvar j = i + 1; j < LAYERS; j++) begin : g_j
      localparam int unsigned P = pair_index(i, j, LAYERS);

      mixer_pair_det #(
        .HIT_CNT_W(HIT_CNT_W)
      ) u_det (
        .clk_vga     (clk_vga),
        .rst         (rst),
        .hit_px      (disp1 & a1[i] & a1[j]),
        .frame_start (fs1),
        .hit         (hit_o[P])
`ifdef MIXER_HIT_COUNT_EN
        , .hit_cnt   (hit_cnt_o[P*HIT_CNT_W +: HIT_CNT_W])
`endif
      );
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// Scoreboard bench for layer_mixer: directed pixels with hand-computed colours and frame reports.
module tb_layer_mixer;

  localparam int unsigned LAYERS = 4;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned PAIRS  = 6;
`ifdef MIXER_HIT_COUNT_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 10;
`endif

  logic                    clk_vga = 1'b0;
  logic                    rst = 1'b1;
  logic                    disp_i = 1'b0;
  logic                    frame_start_i = 1'b0;
  logic [LAYERS*RGB_W-1:0] layer_rgb_i = 48'hFFF_00F_0F0_F00;
  logic [LAYERS-1:0]       layer_alpha_i = '0;
  logic [LAYERS-1:0]       layer_en_i = '1;
  logic [RGB_W-1:0]        rgb_o;
  logic                    disp_o;
  logic [PAIRS-1:0]        hit_o;
  logic                    hit_valid_o;
`ifdef MIXER_HIT_COUNT_EN
  logic [PAIRS*CW-1:0]     hit_cnt_o;
`endif

  layer_mixer #(
    .LAYERS    (LAYERS),
    .RGB_W     (RGB_W),
    .BG_RGB    (12'h123),
    .HIT_CNT_W (CW)
  ) dut (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .disp_i        (disp_i),
    .frame_start_i (frame_start_i),
    .layer_rgb_i   (layer_rgb_i),
    .layer_alpha_i (layer_alpha_i),
    .layer_en_i    (layer_en_i),
    .rgb_o         (rgb_o),
    .disp_o        (disp_o),
    .hit_o         (hit_o),
    .hit_valid_o   (hit_valid_o)
`ifdef MIXER_HIT_COUNT_EN
    , .hit_cnt_o   (hit_cnt_o)
`endif
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct {
    int          stamp;
    logic [5:0]  hit;
    bit          chk_cnt;
    logic [23:0] cnt;
  } rep_t;

  logic [12:0] pix_q[$];
  rep_t        rep_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [5:0]  held = '0;
  bit          cnt_chk = 1'b0;
  logic [23:0] cnt_exp = '0;

  // Drive one pixel at the negedge; expectations are queued for the monitor.
  task automatic px(input logic [3:0] alpha, input logic [3:0] en, input logic disp,
                    input logic fs, input logic r, input logic [11:0] exp_rgb,
                    input logic [5:0] exp_hit);
    rep_t rp;
    @(negedge clk_vga);
    layer_alpha_i = alpha;
    layer_en_i    = en;
    disp_i        = disp;
    frame_start_i = fs;
    rst           = r;
    if (r) begin
      if (pix_q.size() > 0) pix_q[pix_q.size()-1] = '0;
      pix_q.push_back('0);
      rep_q.delete();
    end else begin
      pix_q.push_back({disp, exp_rgb});
      if (fs) begin
        rp.stamp   = cyc + 1;
        rp.hit     = exp_hit;
        rp.chk_cnt = cnt_chk;
        rp.cnt     = cnt_exp;
        rep_q.push_back(rp);
        cnt_chk = 1'b0;
      end
    end
  endtask

  initial begin : monitor
    logic        r;
    logic [12:0] e;
    rep_t        rp;
    forever begin
      @(posedge clk_vga);
      cyc++;
      r = rst;
      #1;
      if (pix_q.size() >= 2) begin
        e = pix_q.pop_front();
        checks++;
        if ({disp_o, rgb_o} !== e) begin
          errors++;
          $display("FAIL pixel cyc=%0d got disp=%b rgb=%h, expected disp=%b rgb=%h",
                   cyc, disp_o, rgb_o, e[12], e[11:0]);
        end
      end
      if (r) begin
        held = '0;
        checks++;
        if (hit_valid_o !== 1'b0 || hit_o !== 6'b0) begin
          errors++;
          $display("FAIL reset_hit cyc=%0d got hit_valid=%b hit=%b, expected 0/000000",
                   cyc, hit_valid_o, hit_o);
        end
      end else if (hit_valid_o === 1'b1) begin
        checks++;
        if (rep_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_report cyc=%0d got hit_valid=1 hit=%b, expected no report",
                   cyc, hit_o);
        end else begin
          rp = rep_q.pop_front();
          held = rp.hit;
          if (rp.stamp + 1 != cyc || hit_o !== rp.hit) begin
            errors++;
            $display("FAIL report cyc=%0d got hit=%b, expected hit=%b at cyc=%0d",
                     cyc, hit_o, rp.hit, rp.stamp + 1);
          end
`ifdef MIXER_HIT_COUNT_EN
          if (rp.chk_cnt) begin
            checks++;
            if (hit_cnt_o !== rp.cnt[PAIRS*CW-1:0]) begin
              errors++;
              $display("FAIL hit_cnt cyc=%0d got %h, expected %h", cyc, hit_cnt_o, rp.cnt);
            end
          end
`endif
        end
      end else begin
        if (rep_q.size() > 0 && rep_q[0].stamp + 1 <= cyc) begin
          rp = rep_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_report cyc=%0d got hit_valid=0, expected pulse with hit=%b",
                   cyc, rp.hit);
        end
        checks++;
        if (hit_o !== held) begin
          errors++;
          $display("FAIL hit_hold cyc=%0d got hit=%b, expected %b", cyc, hit_o, held);
        end
      end
    end
  end

  initial begin : driver
    // alpha, en, disp, fs, rst, exp_rgb, exp_hit
    px(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 12'h000, 6'b0);
    px(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 12'h000, 6'b0);
    // priority select
    px(4'b1111, 4'hF, 1'b1, 1'b0, 1'b0, 12'hF00, 6'b0);
    px(4'b1110, 4'hF, 1'b1, 1'b0, 1'b0, 12'h0F0, 6'b0);
    px(4'b1100, 4'hF, 1'b1, 1'b0, 1'b0, 12'h00F, 6'b0);
    px(4'b1000, 4'hF, 1'b1, 1'b0, 1'b0, 12'hFFF, 6'b0);
    // background and blanking
    px(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 12'h123, 6'b0);
    px(4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 12'h000, 6'b0);
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b111111);
    // layers 1 and 3 overlap on 5 pixels -> pair 4
    repeat (5) px(4'b1010, 4'hF, 1'b1, 1'b0, 1'b0, 12'h0F0, 6'b0);
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b010000);
    px(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 12'h000, 6'b0);
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b000000);
    // layer 1 masked out
    repeat (3) px(4'b0011, 4'b1101, 1'b1, 1'b0, 1'b0, 12'hF00, 6'b0);
    px(4'b0010, 4'b1101, 1'b1, 1'b0, 1'b0, 12'h123, 6'b0);
    // overlap coincident with frame_start joins the new frame; back-to-back pulses
    px(4'b0101, 4'hF, 1'b1, 1'b1, 1'b0, 12'hF00, 6'b000000);
    px(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0, 12'h123, 6'b000010);
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b000000);
    // 20 overlaps on pair (0,2): 4-bit counter saturates at 15
    repeat (20) px(4'b0101, 4'hF, 1'b1, 1'b0, 1'b0, 12'hF00, 6'b0);
    cnt_chk = 1'b1;
    cnt_exp = 24'h0000F0;
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b000010);
    // reset mid-frame discards the pair (0,1) overlap
    repeat (2) px(4'b0011, 4'hF, 1'b1, 1'b0, 1'b0, 12'hF00, 6'b0);
    px(4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 12'h000, 6'b0);
    repeat (2) px(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 12'h000, 6'b0);
    px(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 12'h000, 6'b000000);
    repeat (4) px(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 12'h000, 6'b0);
    @(negedge clk_vga);
    checks++;
    if (rep_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding reports, expected 0", rep_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
